// File: rtl/soc_data_mem_ctrl.sv
// M-stage data RAM/ROM access controller: full-word stores, sub-word stores, loads and error pulses.
// Define SOC_MEM_RMW_EN to build sub-word stores as a one-stall read-modify-write; otherwise byte enables are used.
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module soc_data_mem_ctrl #(
    parameter int XLEN = `XLEN_64b,
    localparam int W = 1 << (XLEN + 4),
    localparam int B = XLEN + 1,
    localparam int NB = W / 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic          i_sw_m,
    input  logic [W-1:0]  i_mem_data_m,
    input  logic [W-1:0]  i_mem_addr_m,
    input  logic          i_store_byte_m,
    input  logic          i_store_half_m,
    input  logic          i_data_rom_en_m,
    input  logic          i_data_ram_en_m,
    output logic          o_stall_m,
    output logic [W-B-1:0] o_ram_addr,
    output logic [W-1:0]  o_ram_wdata,
    output logic [NB-1:0] o_ram_be,
    output logic          o_ram_we,
    output logic          o_ram_re,
    input  logic [W-1:0]  i_ram_rdata,
    output logic [W-B-1:0] o_rom_addr,
    output logic          o_rom_re,
    input  logic [W-1:0]  i_rom_rdata,
    output logic [W-1:0]  o_load_data_w,
    output logic          o_load_valid_w,
    output logic          o_store_err
);

    logic         active;
    logic         rom_only;
    logic         ram_only;
    logic         conflict;
    logic         is_load;
    logic         half_only;
    logic         misaligned;
    logic         bad_req;
    logic         ram_store;
    logic         sub_store;
    logic         src_rom;
    logic [B-1:0] byte_lane;
    logic [B-2:0] half_lane;

    // Strobes are suppressed while reset is held so nothing reaches the memories mid-reset.
    assign active     = i_clk_en & ~i_rst;
    assign rom_only   = i_data_rom_en_m & ~i_data_ram_en_m;
    assign ram_only   = i_data_ram_en_m & ~i_data_rom_en_m;
    assign conflict   = i_data_rom_en_m & i_data_ram_en_m;
    assign is_load    = ~i_sw_m & (rom_only | ram_only);
    assign half_only  = i_store_half_m & ~i_store_byte_m;
    assign misaligned = half_only & i_mem_addr_m[0];
    assign bad_req    = conflict | (i_sw_m & rom_only) | (i_sw_m & ram_only & misaligned);
    assign ram_store  = i_sw_m & ram_only & ~misaligned;
    assign sub_store  = i_store_byte_m | i_store_half_m;
    assign byte_lane  = i_mem_addr_m[B-1:0];
    assign half_lane  = i_mem_addr_m[B-1:1];

    assign o_ram_addr = i_mem_addr_m[W-1:B];
    assign o_rom_addr = i_mem_addr_m[W-1:B];
    assign o_rom_re   = active & is_load & rom_only;

`ifdef SOC_MEM_RMW_EN
    typedef enum logic {IDLE, RD} state_t;

    state_t       state;
    logic         start_rmw;
    logic [W-1:0] merged;

    assign start_rmw = active & ram_store & sub_store & (state == IDLE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else if (i_clk_en) begin
            case (state)
                IDLE: if (start_rmw) state <= RD;
                RD:   state <= IDLE;
            endcase
        end
    end

    // Upstream holds the request during the stall, so the lane and data are still valid in RD.
    always_comb begin
        merged = i_ram_rdata;
        if (i_store_byte_m) begin
            merged[8*byte_lane +: 8] = i_mem_data_m[7:0];
        end else begin
            merged[16*half_lane +: 16] = i_mem_data_m[15:0];
        end
    end

    assign o_stall_m   = start_rmw;
    assign o_ram_re    = active & ((is_load & ram_only) | start_rmw);
    assign o_ram_we    = active & ((state == RD) | (ram_store & ~sub_store));
    assign o_ram_wdata = (state == RD) ? merged : i_mem_data_m;
    assign o_ram_be    = '1;
`else
    assign o_stall_m = 1'b0;
    assign o_ram_re  = active & is_load & ram_only;
    assign o_ram_we  = active & ram_store;

    // Sub-word data is replicated to every lane; the byte enables pick the real target.
    always_comb begin
        o_ram_wdata = i_mem_data_m;
        o_ram_be    = '1;
        if (i_store_byte_m) begin
            o_ram_wdata = {NB{i_mem_data_m[7:0]}};
            o_ram_be    = {{(NB-1){1'b0}}, 1'b1} << byte_lane;
        end else if (i_store_half_m) begin
            o_ram_wdata = {(NB/2){i_mem_data_m[15:0]}};
            o_ram_be    = {{(NB-2){1'b0}}, 2'b11} << {half_lane, 1'b0};
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_load_valid_w <= 1'b0;
            o_store_err    <= 1'b0;
            src_rom        <= 1'b0;
        end else if (i_clk_en) begin
            o_load_valid_w <= is_load;
            o_store_err    <= bad_req;
            if (is_load) src_rom <= rom_only;
        end
    end

    assign o_load_data_w = src_rom ? i_rom_rdata : i_ram_rdata;

endmodule

// File: tb/tb_soc_data_mem_ctrl.sv
// Randomized bench for soc_data_mem_ctrl: a byte-level reference memory predicts every strobe and load.
// Works with or without SOC_MEM_RMW_EN defined.
module tb_soc_data_mem_ctrl;

    localparam int AW = 61;
    localparam int NWORDS = 16;

    logic          i_clk;
    logic          i_rst;
    logic          i_clk_en;
    logic          i_sw_m;
    logic [63:0]   i_mem_data_m;
    logic [63:0]   i_mem_addr_m;
    logic          i_store_byte_m;
    logic          i_store_half_m;
    logic          i_data_rom_en_m;
    logic          i_data_ram_en_m;
    logic          o_stall_m;
    logic [AW-1:0] o_ram_addr;
    logic [63:0]   o_ram_wdata;
    logic [7:0]    o_ram_be;
    logic          o_ram_we;
    logic          o_ram_re;
    logic [63:0]   ram_rdata;
    logic [AW-1:0] o_rom_addr;
    logic          o_rom_re;
    logic [63:0]   rom_rdata;
    logic [63:0]   o_load_data_w;
    logic          o_load_valid_w;
    logic          o_store_err;

    logic [63:0]   ram_mem [NWORDS];
    logic [63:0]   ref_mem [NWORDS];
    logic          tb_init;
    bit            pending;
    bit            exp_valid;
    bit            exp_err;
    logic [63:0]   exp_data;
    int            check_count;
    int            pass_count;

    soc_data_mem_ctrl dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_clk_en        (i_clk_en),
        .i_sw_m          (i_sw_m),
        .i_mem_data_m    (i_mem_data_m),
        .i_mem_addr_m    (i_mem_addr_m),
        .i_store_byte_m  (i_store_byte_m),
        .i_store_half_m  (i_store_half_m),
        .i_data_rom_en_m (i_data_rom_en_m),
        .i_data_ram_en_m (i_data_ram_en_m),
        .o_stall_m       (o_stall_m),
        .o_ram_addr      (o_ram_addr),
        .o_ram_wdata     (o_ram_wdata),
        .o_ram_be        (o_ram_be),
        .o_ram_we        (o_ram_we),
        .o_ram_re        (o_ram_re),
        .i_ram_rdata     (ram_rdata),
        .o_rom_addr      (o_rom_addr),
        .o_rom_re        (o_rom_re),
        .i_rom_rdata     (rom_rdata),
        .o_load_data_w   (o_load_data_w),
        .o_load_valid_w  (o_load_valid_w),
        .o_store_err     (o_store_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] init_word(input int idx);
        if (idx == 2) return 64'h1122334455667788;
        return {idx[15:0], 16'hC0DE, idx[15:0] ^ 16'h5A5A, 16'h0F0F};
    endfunction

    function automatic logic [63:0] rom_word(input logic [AW-1:0] idx);
        return {3'b000, idx} * 64'h9E3779B97F4A7C15 + 64'd1;
    endfunction

    function automatic logic [63:0] merge_be(input logic [63:0] old, input logic [63:0] wdata,
                                             input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = wdata[8*b +: 8];
        return r;
    endfunction

    // Synchronous write-first RAM and registered ROM surrounding the controller.
    always @(posedge i_clk) begin
        if (tb_init) begin
            for (int i = 0; i < NWORDS; i++) ram_mem[i] <= init_word(i);
        end else begin
            if (o_ram_we)
                ram_mem[o_ram_addr[3:0]] <= merge_be(ram_mem[o_ram_addr[3:0]], o_ram_wdata, o_ram_be);
            if (o_ram_re)
                ram_rdata <= o_ram_we ? merge_be(ram_mem[o_ram_addr[3:0]], o_ram_wdata, o_ram_be)
                                      : ram_mem[o_ram_addr[3:0]];
        end
        if (o_rom_re) rom_rdata <= rom_word(o_rom_addr);
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    endtask

    task automatic applyStimulus(input bit en, input bit sw, input bit rom, input bit ram,
                                 input bit sb, input bit sh, input logic [63:0] addr,
                                 input logic [63:0] data);
        i_clk_en        = en;
        i_sw_m          = sw;
        i_data_rom_en_m = rom;
        i_data_ram_en_m = ram;
        i_store_byte_m  = sb;
        i_store_half_m  = sh;
        i_mem_addr_m    = addr;
        i_mem_data_m    = data;
    endtask

    // Called just after a rising edge: predicts this cycle from the request, checks, then advances the model.
    task automatic runCycle();
        logic [AW-1:0] word;
        logic [2:0]    lane;
        logic [63:0]   new_word;
        logic [63:0]   exp_wdata;
        logic [7:0]    exp_be;
        bit rom_only, ram_only, is_load, bad, good_store, sub;
        bit exp_we, exp_re, exp_rom_re, exp_stall;

        word      = i_mem_addr_m[63:3];
        lane      = i_mem_addr_m[2:0];
        rom_only  = i_data_rom_en_m && !i_data_ram_en_m;
        ram_only  = i_data_ram_en_m && !i_data_rom_en_m;
        is_load   = !i_sw_m && (rom_only || ram_only);
        bad       = (i_data_rom_en_m && i_data_ram_en_m) || (i_sw_m && rom_only) ||
                    (i_sw_m && ram_only && i_store_half_m && !i_store_byte_m && i_mem_addr_m[0]);
        good_store = i_sw_m && ram_only && !bad;
        sub       = i_store_byte_m || i_store_half_m;
        exp_we = 0; exp_re = 0; exp_rom_re = 0; exp_stall = 0;
        exp_be = 8'hFF; exp_wdata = '0;

        new_word = ref_mem[word[3:0]];
        if (i_store_byte_m) new_word[8*lane +: 8] = i_mem_data_m[7:0];
        else if (i_store_half_m) new_word[8*lane +: 16] = i_mem_data_m[15:0];
        else new_word = i_mem_data_m;

        if (i_clk_en) begin
            if (good_store) begin
`ifdef SOC_MEM_RMW_EN
                if (sub && !pending) begin
                    exp_re = 1; exp_stall = 1;
                end else begin
                    exp_we = 1; exp_be = 8'hFF; exp_wdata = new_word;
                end
`else
                exp_we = 1;
                if (!sub) begin
                    exp_be = 8'hFF; exp_wdata = i_mem_data_m;
                end else if (i_store_byte_m) begin
                    exp_be = 8'h01 << lane; exp_wdata = {8{i_mem_data_m[7:0]}};
                end else begin
                    exp_be = 8'h03 << lane; exp_wdata = {4{i_mem_data_m[15:0]}};
                end
`endif
            end
            if (is_load && ram_only) exp_re = 1;
            if (is_load && rom_only) exp_rom_re = 1;
        end

        #2;
        checkOutput("ram_we", o_ram_we, exp_we);
        checkOutput("ram_re", o_ram_re, exp_re);
        checkOutput("rom_re", o_rom_re, exp_rom_re);
        if (i_clk_en) checkOutput("stall", o_stall_m, exp_stall);
        if (exp_we) begin
            checkOutput("ram_be", o_ram_be, exp_be);
            checkOutput("ram_wdata", o_ram_wdata, exp_wdata);
        end
        if (exp_we || exp_re) checkOutput("ram_addr", o_ram_addr, word);
        if (exp_rom_re) checkOutput("rom_addr", o_rom_addr, word);

        @(posedge i_clk);
        if (i_clk_en) begin
            if (good_store) begin
                if (exp_stall) pending = 1;
                else begin
                    ref_mem[word[3:0]] = new_word;
                    pending = 0;
                end
            end
            exp_valid = is_load;
            exp_err   = bad;
            if (is_load) exp_data = ram_only ? ref_mem[word[3:0]] : rom_word(word);
        end
        #1;
        checkOutput("load_valid", o_load_valid_w, exp_valid);
        checkOutput("store_err", o_store_err, exp_err);
        if (exp_valid) checkOutput("load_data", o_load_data_w, exp_data);
    endtask

    initial begin
        bit          en_r, sw_r, rom_r, ram_r, sb_r, sh_r, consumed;
        int          kind;
        logic [63:0] a, d;

        check_count = 0;
        pass_count  = 0;
        pending     = 0;
        exp_valid   = 0;
        exp_err     = 0;
        exp_data    = '0;
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_word(i);

        // A live sub-word store request must not leak any strobe while reset is held.
        i_rst   = 1'b1;
        tb_init = 1'b1;
        applyStimulus(1, 1, 0, 1, 1, 0, 64'h13, 64'hAB);
        #1;
        checkOutput("rst_we", o_ram_we, 0);
        checkOutput("rst_re", o_ram_re, 0);
        checkOutput("rst_stall", o_stall_m, 0);
        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_valid", o_load_valid_w, 0);
        checkOutput("rst_err", o_store_err, 0);
        i_rst   = 1'b0;
        tb_init = 1'b0;

        applyStimulus(1, 1, 0, 1, 0, 0, 64'h10, 64'h1122334455667788);
        runCycle();
        applyStimulus(1, 1, 0, 1, 1, 0, 64'h13, 64'hAB);
        runCycle();
        if (pending) runCycle();
        applyStimulus(1, 0, 0, 1, 0, 0, 64'h10, 64'h0);
        runCycle();
        checkOutput("tp_byte_word", o_load_data_w, 64'h11223344AB667788);
        applyStimulus(1, 1, 0, 1, 0, 1, 64'h16, 64'hBEEF);
        runCycle();
        if (pending) runCycle();
        applyStimulus(1, 0, 0, 1, 0, 0, 64'h10, 64'h0);
        runCycle();
        checkOutput("tp_half_word", o_load_data_w, 64'hBEEF3344AB667788);
        applyStimulus(1, 0, 1, 0, 0, 0, 64'h8, 64'h0);
        runCycle();
        checkOutput("tp_rom_word", o_load_data_w, rom_word(1));

        // Error cases, each followed by an idle cycle so the pulse must drop.
        applyStimulus(1, 1, 1, 0, 0, 0, 64'h20, 64'h1234);
        runCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        runCycle();
        applyStimulus(1, 1, 0, 1, 0, 1, 64'h11, 64'hCAFE);
        runCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        runCycle();
        applyStimulus(1, 1, 1, 1, 0, 0, 64'h18, 64'h77);
        runCycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        runCycle();

        // Reset lands while a sub-word store is in flight; the word must stay untouched.
        applyStimulus(1, 1, 0, 1, 1, 0, 64'h2A, 64'h55);
`ifdef SOC_MEM_RMW_EN
        runCycle();
`endif
        i_rst = 1'b1;
        #1;
        checkOutput("midrst_we", o_ram_we, 0);
        checkOutput("midrst_stall", o_stall_m, 0);
        @(posedge i_clk);
        #1;
        checkOutput("midrst_we_held", o_ram_we, 0);
        checkOutput("midrst_valid", o_load_valid_w, 0);
        pending   = 0;
        exp_valid = 0;
        exp_err   = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        i_rst = 1'b0;
        applyStimulus(1, 0, 0, 1, 0, 0, 64'h28, 64'h0);
        runCycle();

        consumed = 1;
        sw_r = 0; rom_r = 0; ram_r = 0; sb_r = 0; sh_r = 0; a = '0; d = '0;
        for (int n = 0; n < 600; n++) begin
            en_r = ($urandom_range(0, 9) != 0);
            if (consumed) begin
                kind = $urandom_range(0, 9);
                a    = {57'b0, 7'($urandom_range(0, 127))};
                d    = {$urandom, $urandom};
                sw_r = 0; rom_r = 0; ram_r = 0; sb_r = 0; sh_r = 0;
                case (kind)
                    1, 2: ram_r = 1;
                    3:    rom_r = 1;
                    4:    begin sw_r = 1; ram_r = 1; end
                    5, 6: begin sw_r = 1; ram_r = 1; sb_r = 1; end
                    7: begin
                        sw_r = 1; ram_r = 1; sh_r = 1;
                        if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
                    end
                    8: begin
                        sw_r = 1; rom_r = 1;
                        sb_r = ($urandom_range(0, 2) == 0);
                    end
                    9: begin
                        sw_r = ($urandom_range(0, 1) == 1); rom_r = 1; ram_r = 1;
                    end
                    default: ;
                endcase
            end
            applyStimulus(en_r, sw_r, rom_r, ram_r, sb_r, sh_r, a, d);
            runCycle();
            consumed = en_r && !pending;
        end

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/soc_data_mem_ctrl.md
# soc_data_mem_ctrl

Memory-stage access controller sitting directly downstream of the E→M pipeline register. Consumes the registered M-stage store/load request (store flag, address, data, byte/half qualifiers, ROM/RAM enables). Drives the synchronous data RAM and data ROM, and returns the full read word to the writeback path one cycle later. Sub-word stores are performed as a read-modify-write (RMW) sequence that stalls the pipeline for one cycle.

## Interface
Parameters:
- XLEN, default `XLEN_64b`: width code. Data width W = 1<<(XLEN+4); byte-offset bits B = XLEN+1; word index = addr[W-1:B].

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset; asynchronous, active-high.
- i_clk_en  in  1  clock enable. When low: FSM holds, all RAM/ROM strobes forced 0, registered outputs hold.
- i_sw_m  in  1  store request.
- i_mem_data_m  in  W  store data; sub-word data in low bits.
- i_mem_addr_m  in  W  byte address.
- i_store_byte_m / i_store_half_m  in  1  sub-word store qualifiers; neither set = full word.
- i_data_rom_en_m / i_data_ram_en_m  in  1  target select.
- o_stall_m  out  1  combinational stall to upstream pipe/hazard logic.
- o_ram_addr  out  W-B  RAM word index.
- o_ram_wdata  out  W  RAM write data.
- o_ram_be  out  W/8  RAM byte enables.
- o_ram_we, o_ram_re  out  1  RAM write/read strobes.
- i_ram_rdata  in  W  RAM read data, valid the cycle after o_ram_re.
- o_rom_addr  out  W-B  ROM word index.
- o_rom_re  out  1  ROM read strobe.
- i_rom_rdata  in  W  ROM data, valid the cycle after o_rom_re.
- o_load_data_w  out  W  full read word to writeback.
- o_load_valid_w  out  1  registered; o_load_data_w valid this cycle.
- o_store_err  out  1  registered one-cycle error pulse.

## Operation
- Request decode: store = i_sw_m & exactly one enable set. Load = ~i_sw_m & exactly one enable set. Both enables set = conflict: no access, o_store_err pulses.
- Full-word RAM store: o_ram_we=1, o_ram_be all ones, o_ram_wdata=i_mem_data_m. Single cycle, no stall.
- Store to ROM: dropped, o_store_err pulses.
- Misaligned half store (addr[0]=1): dropped, o_store_err pulses.
- Sub-word RAM store uses FSM IDLE/RD. Behaviour is per Configuration.
- Load: o_ram_re or o_rom_re asserted in the request cycle. Source select registered. Next cycle: o_load_valid_w=1 and o_load_data_w = selected rdata. Sub-word extraction and sign handling belong to writeback, not this block.
- Lane select: byte lane = addr[B-1:0]; half lane = addr[B-1:1].

## Timing
- Reset values: FSM=IDLE, o_load_valid_w=0, o_store_err=0, source select=RAM.
- Combinational outputs during reset: o_stall_m=0, all strobes 0.
- Reset asserted mid-RMW: no write issued, FSM returns to IDLE.
- RMW sequence, cycle 0 (IDLE, sub-word RAM store): o_ram_re=1, o_stall_m=1, next state RD.
- RMW sequence, cycle 1 (RD): merge i_ram_rdata with the selected lane of i_mem_data_m; o_ram_we=1, o_ram_be all ones, o_stall_m=0; next state IDLE.
- Upstream holds M-stage inputs stable while o_stall_m=1.
- RMW read data is never presented as load data: o_load_valid_w stays 0.
- Load latency is 1 cycle. Back-to-back loads are sustained at 1 per cycle.
- A load directly following an RMW write reads the merged data (RAM is write-first).

## Configuration
- SOC_MEM_RMW_EN defined: sub-word stores use the RMW FSM above (1 stall cycle); o_ram_be is always all ones.
- SOC_MEM_RMW_EN undefined: sub-word stores complete in a single cycle. Data is replicated across lanes and o_ram_be enables only the target byte(s). FSM is removed and o_stall_m is tied 0.

## Test plan
- Reset, then full-word store: addr 0x10, data 0x1122334455667788 → o_ram_we=1, o_ram_addr=2, o_ram_be=0xFF, no stall.
- RMW_EN on, byte store: addr 0x13, data 0xAB, RAM word 0x1122334455667788 → 1 stall cycle; write 0x11223344AB667788.
- RMW_EN off, half store: addr 0x16, data 0xBEEF → o_ram_be=0xC0, o_ram_wdata[63:48]=0xBEEF, no stall.
- ROM load: addr 0x8 → o_rom_re=1, o_rom_addr=1; next cycle o_load_valid_w=1, data = i_rom_rdata.
- Error cases: store to ROM, half store to addr 0x11, and both enables set → each gives o_store_err one-cycle pulse and no we.
- i_rst asserted during RD → o_ram_we never asserted; o_stall_m=0 immediately.
